// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: sequences CPU and video accesses onto an async SRAM.
// Optional video port: define MEMC_VIDPORT_EN to enable it.
module sram_mem_ctrl #(
   parameter int DATAWIDTH   = 16,
   parameter int ADDRWIDTH   = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cpu_ce_n,
   input  logic                 cpu_oe_n,
   input  logic                 cpu_we_n,
   input  logic [ADDRWIDTH-1:0] cpu_addr,
   input  logic [DATAWIDTH-1:0] cpu_din,
   output logic [DATAWIDTH-1:0] cpu_dout,
   output logic                 cpu_ready,
   input  logic                 vid_req,
   input  logic [ADDRWIDTH-1:0] vid_addr,
   output logic [DATAWIDTH-1:0] vid_data,
   output logic                 vid_valid,
   output logic [ADDRWIDTH-1:0] sram_addr,
   output logic [DATAWIDTH-1:0] sram_dq_out,
   output logic                 sram_dq_oe,
   input  logic [DATAWIDTH-1:0] sram_dq_in,
   output logic                 sram_ce_n,
   output logic                 sram_oe_n,
   output logic                 sram_we_n
);

   localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

`ifdef MEMC_VIDPORT_EN
   typedef enum logic [2:0] {IDLE, CRD, CWR, WREC, VRD} state_t;
`else
   typedef enum logic [2:0] {IDLE, CRD, CWR, WREC} state_t;
`endif

   state_t        state;
   logic [CW-1:0] cnt;
   logic          cpu_done;
   logic          cpu_req;

   // cpu_done blocks a held strobe from being serviced twice
   assign cpu_req = !cpu_ce_n && (!cpu_oe_n || !cpu_we_n) && !cpu_done;

`ifndef MEMC_VIDPORT_EN
   assign vid_data  = '0;
   assign vid_valid = 1'b0;
   logic unused_vid;
   assign unused_vid = ^{vid_req, vid_addr};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cpu_done    <= 1'b0;
         cpu_dout    <= '0;
         cpu_ready   <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
`ifdef MEMC_VIDPORT_EN
         vid_data    <= '0;
         vid_valid   <= 1'b0;
`endif
      end else begin
         cpu_ready <= 1'b0;
`ifdef MEMC_VIDPORT_EN
         vid_valid <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (cpu_req) begin
                  sram_addr <= cpu_addr;
                  cnt       <= CNT_LOAD;
                  sram_ce_n <= 1'b0;
                  // write wins when both strobes are low
                  if (!cpu_we_n) begin
                     state       <= CWR;
                     sram_dq_out <= cpu_din;
                     sram_we_n   <= 1'b0;
                     sram_dq_oe  <= 1'b1;
                  end else begin
                     state     <= CRD;
                     sram_oe_n <= 1'b0;
                  end
               end
`ifdef MEMC_VIDPORT_EN
               else if (vid_req) begin
                  state     <= VRD;
                  sram_addr <= vid_addr;
                  cnt       <= CNT_LOAD;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
               end
`endif
            end
            CRD: begin
               if (cnt == '0) begin
                  state     <= IDLE;
                  cpu_dout  <= sram_dq_in;
                  cpu_ready <= 1'b1;
                  cpu_done  <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            CWR: begin
               if (cnt == '0) begin
                  // release we_n but keep ce_n and data driven for hold
                  state     <= WREC;
                  sram_we_n <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WREC: begin
               state      <= IDLE;
               cpu_ready  <= 1'b1;
               cpu_done   <= 1'b1;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
`ifdef MEMC_VIDPORT_EN
            VRD: begin
               if (cnt == '0) begin
                  state     <= IDLE;
                  vid_data  <= sram_dq_in;
                  vid_valid <= 1'b1;
                  sram_ce_n <= 1'b1;
                  sram_oe_n <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
         // deselect re-arms the CPU port; overrides a same-edge set
         if (cpu_ce_n) cpu_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed checks of sram_mem_ctrl against an SRAM model.
// Covers reset, reads, writes, held strobes, arbitration and async reset.
module tb_sram_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_ce_n, cpu_oe_n, cpu_we_n;
   logic [15:0] cpu_addr, cpu_din, cpu_dout;
   logic        cpu_ready;
   logic        vid_req;
   logic [15:0] vid_addr, vid_data;
   logic        vid_valid;
   logic [15:0] sram_addr, sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sram_mem_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_ce_n(cpu_ce_n), .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n),
      .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_ready(cpu_ready),
      .vid_req(vid_req), .vid_addr(vid_addr),
      .vid_data(vid_data), .vid_valid(vid_valid),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
      .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
      .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
      .sram_we_n(sram_we_n)
   );

   // async SRAM model: combinational read, write while ce/we low
   logic [15:0] mem [0:65535];
   bit init_done = 1'b0;
   assign sram_dq_in = mem[sram_addr];

   always @(posedge clk) begin
      if (!init_done) begin
         mem[16'h0040] <= 16'hBEEF;
         mem[16'h0200] <= 16'h00AA;
         mem[16'h0010] <= 16'h0000;
         init_done     <= 1'b1;
      end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         mem[sram_addr] <= sram_dq_out;
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cpu_op(input bit wr,
                         input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] rd,
                         output int act, output int rec,
                         output logic [15:0] sa);
      @(negedge clk);
      cpu_addr = a;
      cpu_din  = d;
      cpu_ce_n = 1'b0;
      cpu_we_n = !wr;
      cpu_oe_n = wr;
      lat = -1;
      rd  = '0;
      act = 0;
      rec = 0;
      sa  = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            cpu_addr = ~a;
            cpu_din  = ~d;
         end
         if (k == 2) sa = sram_addr;
         if (wr ? !sram_we_n : !sram_oe_n) act++;
         if (!sram_ce_n && sram_we_n && sram_oe_n && sram_dq_oe) rec++;
         if (cpu_ready) begin
            lat = k - 1;
            rd  = cpu_dout;
            break;
         end
      end
      cpu_ce_n = 1'b1;
      cpu_oe_n = 1'b1;
      cpu_we_n = 1'b1;
   endtask

   int          lat, act, rec, cnt, rk, vk, vcnt;
   logic [15:0] rd, sa, vd;

   initial begin
      rst      = 1'b0;
      cpu_ce_n = 1'b1;
      cpu_oe_n = 1'b1;
      cpu_we_n = 1'b1;
      cpu_addr = '0;
      cpu_din  = '0;
      vid_req  = 1'b0;
      vid_addr = '0;
      repeat (3) @(negedge clk);

      check("rst_dout",  32'(cpu_dout), 32'h0);
      check("rst_ready", 32'(cpu_ready), 32'h0);
      check("rst_vvalid", 32'(vid_valid), 32'h0);
      check("rst_vdata", 32'(vid_data), 32'h0);
      check("rst_addr",  32'(sram_addr), 32'h0);
      check("rst_dqout", 32'(sram_dq_out), 32'h0);
      check("rst_strobes",
            32'({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}), 32'he);
      rst = 1'b1;
      @(negedge clk);

      // read 0x0040 -> 0xBEEF, 2-edge latency
      cpu_op(1'b0, 16'h0040, 16'h0, lat, rd, act, rec, sa);
      check("rd_lat",  32'(lat), 32'd2);
      check("rd_data", 32'(rd), 32'hBEEF);
      check("rd_oe",   32'(act), 32'd2);
      check("rd_addr", 32'(sa), 32'h0040);

      // write 0x1234 -> 0x0010, 3-edge latency
      cpu_op(1'b1, 16'h0010, 16'h1234, lat, rd, act, rec, sa);
      check("wr_lat",  32'(lat), 32'd3);
      check("wr_we",   32'(act), 32'd2);
      check("wr_wrec", 32'(rec), 32'd1);
      check("wr_addr", 32'(sa), 32'h0010);

      cpu_op(1'b0, 16'h0010, 16'h0, lat, rd, act, rec, sa);
      check("rb_data", 32'(rd), 32'h1234);
      check("rb_lat",  32'(lat), 32'd2);

      // held strobes: one access; ce_n pulse re-arms
      @(negedge clk);
      cpu_addr = 16'h0040;
      cpu_ce_n = 1'b0;
      cpu_oe_n = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (cpu_ready) cnt++;
      end
      check("held_one", 32'(cnt), 32'd1);
      cpu_ce_n = 1'b1;
      @(negedge clk);
      cpu_ce_n = 1'b0;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (cpu_ready) cnt++;
      end
      check("held_rearm", 32'(cnt), 32'd1);
      cpu_ce_n = 1'b1;
      cpu_oe_n = 1'b1;
      @(negedge clk);

      // CPU read and video request together
      @(negedge clk);
      cpu_addr = 16'h0040;
      cpu_ce_n = 1'b0;
      cpu_oe_n = 1'b0;
      vid_req  = 1'b1;
      vid_addr = 16'h0200;
      rk = -1;
      vk = -1;
      vcnt = 0;
      vd = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (cpu_ready && rk < 0) begin
            rk = k;
            cpu_ce_n = 1'b1;
            cpu_oe_n = 1'b1;
         end
         if (vid_valid) begin
            if (vk < 0) vk = k;
            vcnt++;
            vd = vid_data;
            vid_req = 1'b0;
         end
      end
      vid_req = 1'b0;
      cpu_ce_n = 1'b1;
      cpu_oe_n = 1'b1;
      check("arb_cpu_lat", 32'(rk), 32'd3);
`ifdef MEMC_VIDPORT_EN
      check("arb_vid_lat", 32'(vk), 32'd6);
      check("arb_vid_cnt", 32'(vcnt), 32'd1);
      check("arb_vid_data", 32'(vd), 32'h00AA);
`else
      check("novid_cnt",  32'(vcnt), 32'd0);
      check("novid_data", 32'(vid_data), 32'h0);
`endif

      // async reset mid-write
      @(negedge clk);
      cpu_addr = 16'h0020;
      cpu_din  = 16'h5555;
      cpu_ce_n = 1'b0;
      cpu_we_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("cwr_active", 32'({sram_ce_n, sram_we_n}), 32'h0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_strobes",
            32'({sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}), 32'he);
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (cpu_ready) cnt++;
      end
      check("arst_noready", 32'(cnt), 32'd0);
      cpu_ce_n = 1'b1;
      cpu_we_n = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      cpu_op(1'b0, 16'h0010, 16'h0, lat, rd, act, rec, sa);
      check("post_rst_data", 32'(rd), 32'h1234);
      check("post_rst_lat",  32'(lat), 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Memory-controller responder for the CPU's SRAM strobes. It accepts the CPU's chip, output and write enables, address and write data, and sequences multi-cycle cycles on the external asynchronous SRAM. It returns read data with a one-cycle ready pulse. A lower-priority video read port shares the same SRAM and is arbitrated here.

## Interface
Parameters:
- DATAWIDTH, 16, data bus width
- ADDRWIDTH, 16, SRAM word-address width
- WAIT_CYCLES, 2, SRAM access cycles per read/write strobe (legal ≥1)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_ce_n  in  1  CPU chip enable, active low
- cpu_oe_n  in  1  CPU read request, active low
- cpu_we_n  in  1  CPU write request, active low
- cpu_addr  in  ADDRWIDTH  CPU address
- cpu_din  in  DATAWIDTH  CPU write data
- cpu_dout  out  DATAWIDTH  read data, registered
- cpu_ready  out  1  one-cycle completion pulse
- vid_req  in  1  video read request, level
- vid_addr  in  ADDRWIDTH  video address
- vid_data  out  DATAWIDTH  video read data, registered
- vid_valid  out  1  one-cycle video completion pulse
- sram_addr  out  ADDRWIDTH  SRAM address
- sram_dq_out  out  DATAWIDTH  SRAM write data
- sram_dq_oe  out  1  drive enable for the SRAM data pads
- sram_dq_in  in  DATAWIDTH  SRAM read data
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low

## Operation
- FSM states: IDLE, CRD (CPU read), CWR (CPU write), WREC (write recovery), VRD (video read). A down-counter `cnt` of width clog2(WAIT_CYCLES) sets state duration.
- CPU request definition:
  - Valid when cpu_ce_n=0 and (cpu_oe_n=0 or cpu_we_n=0).
  - Write wins if both oe_n and we_n are low.
  - A request is accepted only when the `cpu_done` flag is clear. The flag sets when cpu_ready pulses and clears on any cycle with cpu_ce_n=1. A held strobe is therefore serviced once.
- IDLE arbitration: a CPU request beats vid_req. A video request is accepted only when no acceptable CPU request is present.
- On acceptance:
  - Latch the address, and for writes the data, into output registers.
  - Load cnt=WAIT_CYCLES-1.
- CRD/VRD:
  - Outputs: sram_ce_n=0, sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
  - At the edge where cnt=0, capture sram_dq_in into cpu_dout or vid_data, pulse cpu_ready or vid_valid, and return to IDLE.
- CWR:
  - Outputs: sram_ce_n=0, sram_we_n=0, sram_oe_n=1, sram_dq_oe=1.
  - At cnt=0 go to WREC.
- WREC: one cycle with sram_ce_n=0, sram_we_n=1, sram_dq_oe=1 (data hold). Then pulse cpu_ready and return to IDLE.
- IDLE outputs: all SRAM strobes high, sram_dq_oe=0, sram_addr holds its last value.
- Input changes mid-access: changes on cpu_addr, cpu_din or vid_addr after acceptance are ignored.
- Video cancel: vid_req dropping before acceptance cancels it. Dropping after acceptance has no effect; vid_valid still pulses.
- Reset values: cpu_dout=0, vid_data=0, cpu_ready=0, vid_valid=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, all SRAM strobes=1, state=IDLE, cpu_done=0.
- Reset asserted mid-access aborts immediately and asynchronously. The SRAM strobes go high and the data pads release in the same instant; no ready pulse is produced.

## Timing
- Acceptance edge E0. All SRAM outputs are registered and valid from E0.
- Read: cpu_ready/vid_valid are high during the cycle after edge E(WAIT_CYCLES). Data is valid in the same cycle and held until the next capture.
- Write: cpu_ready is high after edge E(WAIT_CYCLES+1).
- Next acceptance is possible at the edge after the ready/valid pulse edge. No idle-bus cycle is inserted between a read and a following write beyond that IDLE cycle.
- Throughput with WAIT_CYCLES=2:
  - Read: 3 cycles per access (2 active plus 1 IDLE).
  - Write: 4 cycles per access.

## Configuration
- MEMC_VIDPORT_EN defined: the video port and VRD state are present as described.
- MEMC_VIDPORT_EN undefined:
  - VRD is removed and vid_req/vid_addr are ignored.
  - vid_data=0 and vid_valid=0 permanently.
  - CPU timing is unchanged.

## Test plan
- Reset, then CPU read addr 0x0040 with SRAM model returning 0xBEEF, WAIT_CYCLES=2 → sram_oe_n low for 2 cycles, cpu_ready pulses once 2 edges after acceptance, cpu_dout=0xBEEF.
- CPU write 0x1234 to 0x0010 → sram_we_n low 2 cycles, then WREC with sram_dq_oe=1 and we_n=1. cpu_ready pulses after 3 edges; a readback returns 0x1234.
- CPU strobes held low for 10 cycles → exactly one access and one cpu_ready. Raising ce_n for one cycle then lowering it gives a second access.
- cpu read and vid_req asserted on the same edge (vid_addr 0x0200 holds 0x00AA) → CPU serviced first. VRD starts on the next IDLE edge; vid_valid pulses with vid_data=0x00AA.
- rst driven low mid-CWR → sram_we_n, sram_ce_n=1 and sram_dq_oe=0 without waiting for a clock edge, and no cpu_ready. After release, a new read completes normally.
- Build without MEMC_VIDPORT_EN, vid_req held high → vid_valid never asserts and CPU reads keep the 2-edge latency.
